// File: rtl/univ_reg_hist_pkg.sv
// Shared definitions for the universal register with undo history:
// operation encodings and their width.
package univ_reg_hist_pkg;

   localparam int MODE_W = 3;
   typedef logic [MODE_W-1:0] mode_t;

   localparam mode_t MODE_HOLD = 3'b000;
   localparam mode_t MODE_LOAD = 3'b001;
   localparam mode_t MODE_SHL  = 3'b010;
   localparam mode_t MODE_SHR  = 3'b011;
   localparam mode_t MODE_ROL  = 3'b100;
   localparam mode_t MODE_ROR  = 3'b101;
   localparam mode_t MODE_INC  = 3'b110;
   localparam mode_t MODE_UNDO = 3'b111;

endpackage

// File: rtl/univ_reg_hist_if.sv
// Operation/status bundle between input logic (master) and the register (slave).
interface univ_reg_hist_if
   import univ_reg_hist_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
);
   logic             En;
   mode_t            Mode;
   logic [WIDTH-1:0] D;
   logic             SerIn;
   logic [WIDTH-1:0] Q;
   logic [LW-1:0]    Level;
   logic             Full;
   logic             Empty;
   logic             Err;

   modport master (output En, Mode, D, SerIn,
                   input  Q, Level, Full, Empty, Err);
   modport slave  (input  En, Mode, D, SerIn,
                   output Q, Level, Full, Empty, Err);
endinterface

// File: rtl/univ_reg_hist_hist_stack.sv
// Circular LIFO of past register values; a push when full silently
// overwrites the oldest entry, so the newest DEPTH values are always kept.
module hist_stack #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [LW-1:0]    level_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]    top_q, top_d, top_nxt, top_prv;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // top_q is the next free slot; the newest entry sits one slot behind it.
   assign top_nxt = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + PW'(1);
   assign top_prv = (top_q == '0) ? PW'(DEPTH - 1) : top_q - PW'(1);

   always_comb begin
      top_d = top_q;
      lvl_d = lvl_q;
      if (push_i) begin
         top_d = top_nxt;
         if (lvl_q != LW'(DEPTH)) lvl_d = lvl_q + LW'(1);
      end else if (pop_i && lvl_q != '0) begin
         top_d = top_prv;
         lvl_d = lvl_q - LW'(1);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         top_q <= '0;
         lvl_q <= '0;
      end else begin
         top_q <= top_d;
         lvl_q <= lvl_d;
      end
   end

   // Storage contents are don't-care after reset, so no reset here.
   always_ff @(posedge Clock) begin
      if (push_i) mem_q[top_q] <= din_i;
   end

   assign dout_o  = mem_q[top_prv];
   assign level_o = lvl_q;

endmodule

// File: rtl/univ_reg_hist.sv
// Universal register (load/shift/rotate/increment) with a DEPTH-entry undo
// history; every modifying operation saves the previous Q for later restore.
module univ_reg_hist
   import univ_reg_hist_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic           Clock,
   input  logic           Resetn,
   univ_reg_hist_if.slave bus
);
   logic [WIDTH-1:0] q_q, q_d;
   logic             err_q, err_d;
   logic             push, pop;
   logic [WIDTH-1:0] hist_dout;
   logic [LW-1:0]    level;

   always_comb begin
      q_d   = q_q;
      err_d = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      if (bus.En) begin
         case (bus.Mode)
            MODE_HOLD: ;
            MODE_LOAD: begin q_d = bus.D;                              push = 1'b1; end
            MODE_SHL:  begin q_d = {q_q[WIDTH-2:0], bus.SerIn};        push = 1'b1; end
            MODE_SHR:  begin q_d = {bus.SerIn, q_q[WIDTH-1:1]};        push = 1'b1; end
            MODE_ROL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};     push = 1'b1; end
            MODE_ROR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};           push = 1'b1; end
            MODE_INC:  begin q_d = q_q + WIDTH'(1);                    push = 1'b1; end
            MODE_UNDO: begin
               if (level != '0) begin
                  q_d = hist_dout;
                  pop = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q_q   <= '0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
      end
   end

   // The stack samples the pre-update Q, which is exactly the value to undo to.
   hist_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) u_hist (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (q_q),
      .dout_o  (hist_dout),
      .level_o (level)
   );

   assign bus.Q     = q_q;
   assign bus.Err   = err_q;
   assign bus.Level = level;
   assign bus.Full  = (level == LW'(DEPTH));
   assign bus.Empty = (level == '0);

endmodule

// File: tb/tb_univ_reg_hist.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a monitor pops and compares one entry after each rising edge.
module tb_univ_reg_hist;
   import univ_reg_hist_pkg::*;

   localparam int W  = 3;
   localparam int DP = 4;
   localparam int LW = $clog2(DP + 1);

   typedef struct {
      logic [W-1:0]  q;
      logic [LW-1:0] lvl;
      logic          err;
      string         name;
   } exp_t;

   logic Clock = 1'b0;
   logic Resetn;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   univ_reg_hist_if #(.WIDTH(W), .DEPTH(DP)) bus ();

   univ_reg_hist #(.WIDTH(W), .DEPTH(DP)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   always #5 Clock = ~Clock;

   task automatic compare(input string name, input logic [W-1:0] q,
                          input logic [LW-1:0] lvl, input logic err);
      logic [W+LW+2:0] act, req;
      act = {bus.Q, bus.Level, bus.Full, bus.Empty, bus.Err};
      req = {q, lvl, lvl == LW'(DP), lvl == '0, err};
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got Q=%b Level=%0d Full=%b Empty=%b Err=%b, want Q=%b Level=%0d Full=%b Empty=%b Err=%b",
                  name, bus.Q, bus.Level, bus.Full, bus.Empty, bus.Err,
                  q, lvl, lvl == LW'(DP), lvl == '0, err);
      end
   endtask

   // Monitor: every edge with a pending expectation is checked.
   always @(posedge Clock) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         compare(e.name, e.q, e.lvl, e.err);
      end
   end

   task automatic op(input string name, input logic en, input mode_t m,
                     input logic [W-1:0] d, input logic ser,
                     input logic [W-1:0] eq, input int el, input logic ee);
      exp_t e;
      @(negedge Clock);
      bus.En = en; bus.Mode = m; bus.D = d; bus.SerIn = ser;
      e.q = eq; e.lvl = LW'(el); e.err = ee; e.name = name;
      exp_q.push_back(e);
   endtask

   // Reset dropped and released between edges; checked before the next edge.
   task automatic pulse_reset(input string name);
      @(negedge Clock);
      bus.En = 1'b0;
      Resetn = 1'b0;
      #1 compare(name, '0, '0, 1'b0);
      #1 Resetn = 1'b1;
   endtask

   initial begin
      bus.En = 1'b0; bus.Mode = MODE_HOLD; bus.D = '0; bus.SerIn = 1'b0;
      Resetn = 1'b0;
      #2 compare("reset_state", '0, '0, 1'b0);
      #1 Resetn = 1'b1;

      // Load, shifts, then unwind the history and underflow once.
      op("t2_load",  1, MODE_LOAD, 3'b101, 0, 3'b101, 1, 0);
      op("t2_shl",   1, MODE_SHL,  3'b000, 1, 3'b011, 2, 0);
      op("t2_shr",   1, MODE_SHR,  3'b000, 0, 3'b001, 3, 0);
      op("t2_undo1", 1, MODE_UNDO, 3'b000, 0, 3'b011, 2, 0);
      op("t2_undo2", 1, MODE_UNDO, 3'b000, 0, 3'b101, 1, 0);
      op("t2_undo3", 1, MODE_UNDO, 3'b000, 0, 3'b000, 0, 0);
      op("t2_undo4", 1, MODE_UNDO, 3'b000, 0, 3'b000, 0, 1);
      op("t2_errclr",1, MODE_HOLD, 3'b000, 0, 3'b000, 0, 0);

      // Async reset mid-sequence discards history.
      op("t1_ld1",   1, MODE_LOAD, 3'b001, 0, 3'b001, 1, 0);
      op("t1_ld2",   1, MODE_LOAD, 3'b010, 0, 3'b010, 2, 0);
      op("t1_ld3",   1, MODE_LOAD, 3'b101, 0, 3'b101, 3, 0);
      pulse_reset("t1_async_reset");
      op("t1_undo",  1, MODE_UNDO, 3'b000, 0, 3'b000, 0, 1);

      // Overflow: oldest entry (000) is overwritten.
      pulse_reset("t3_reset");
      op("t3_ld1",   1, MODE_LOAD, 3'b001, 0, 3'b001, 1, 0);
      op("t3_ld2",   1, MODE_LOAD, 3'b010, 0, 3'b010, 2, 0);
      op("t3_ld3",   1, MODE_LOAD, 3'b011, 0, 3'b011, 3, 0);
      op("t3_ld4",   1, MODE_LOAD, 3'b100, 0, 3'b100, 4, 0);
      op("t3_ld5",   1, MODE_LOAD, 3'b101, 0, 3'b101, 4, 0);
      op("t3_undo1", 1, MODE_UNDO, 3'b000, 0, 3'b100, 3, 0);
      op("t3_undo2", 1, MODE_UNDO, 3'b000, 0, 3'b011, 2, 0);
      op("t3_undo3", 1, MODE_UNDO, 3'b000, 0, 3'b010, 1, 0);
      op("t3_undo4", 1, MODE_UNDO, 3'b000, 0, 3'b001, 0, 0);
      op("t3_undo5", 1, MODE_UNDO, 3'b000, 0, 3'b001, 0, 1);

      // Increment wrap and rotates; Level saturates at DEPTH.
      pulse_reset("t4_reset");
      op("t4_ld111", 1, MODE_LOAD, 3'b111, 0, 3'b111, 1, 0);
      op("t4_inc",   1, MODE_INC,  3'b000, 0, 3'b000, 2, 0);
      op("t4_ld100", 1, MODE_LOAD, 3'b100, 0, 3'b100, 3, 0);
      op("t4_rol",   1, MODE_ROL,  3'b000, 0, 3'b001, 4, 0);
      op("t4_ror",   1, MODE_ROR,  3'b000, 0, 3'b100, 4, 0);
      op("t4_undo",  1, MODE_UNDO, 3'b000, 0, 3'b001, 3, 0);

      // En=0 ignores Mode; HOLD changes nothing and does not push.
      op("t5_en0",   0, MODE_LOAD, 3'b110, 0, 3'b001, 3, 0);
      op("t5_hold",  1, MODE_HOLD, 3'b110, 1, 3'b001, 3, 0);
      op("t5_en0u",  0, MODE_UNDO, 3'b000, 0, 3'b001, 3, 0);

      // Shift-in of the other SerIn polarities; push of an unchanged value.
      op("sx_ld010", 1, MODE_LOAD, 3'b010, 0, 3'b010, 4, 0);
      op("sx_shr1",  1, MODE_SHR,  3'b000, 1, 3'b101, 4, 0);
      op("sx_shl0",  1, MODE_SHL,  3'b000, 0, 3'b010, 4, 0);
      op("sx_ldsame",1, MODE_LOAD, 3'b010, 0, 3'b010, 4, 0);
      op("sx_undo",  1, MODE_UNDO, 3'b000, 0, 3'b010, 3, 0);
      op("sx_undo2", 1, MODE_UNDO, 3'b000, 0, 3'b101, 2, 0);

      // Back-to-back rejected undos.
      pulse_reset("t6_reset");
      op("t6_undo1", 1, MODE_UNDO, 3'b000, 0, 3'b000, 0, 1);
      op("t6_undo2", 1, MODE_UNDO, 3'b000, 0, 3'b000, 0, 1);
      op("t6_undo3", 1, MODE_UNDO, 3'b000, 0, 3'b000, 0, 1);
      op("t6_idle",  0, MODE_UNDO, 3'b000, 0, 3'b000, 0, 0);

      @(negedge Clock);
      bus.En = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
